// File: rtl/alu_mext.sv
// alu_mext: RV32I/RV64I register/immediate ALU plus the M extension (multiply/divide).
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst        - asynchronous active-low reset
//   clk_en     - global enable; when low all state is frozen and nothing is accepted
//   i_valid    - operation request, accepted when o_ready & clk_en & !i_flush
//   o_ready    - high while idle
//   i_flush    - abort any in-flight operation and suppress its completion
//   i_opcode, i_funct3, i_funct7 - instruction decode fields
//   i_rs1_data, i_rs2_data, i_imm - operands (i_imm already sign-extended)
//   o_valid    - one-cycle result strobe
//   o_rd_data  - result, held between strobes
module alu_mext #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clk_en,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic            i_flush,
  input  logic [6:0]      i_opcode,
  input  logic [2:0]      i_funct3,
  input  logic [6:0]      i_funct7,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [XLEN-1:0] i_imm,
  output logic            o_valid,
  output logic [XLEN-1:0] o_rd_data
);
  localparam int SW = $clog2(XLEN);
  localparam int MUL_INIT = MUL_CYCLES > 1 ? MUL_CYCLES - 2 : 0;
  localparam logic [1:0] S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2;
  // Funct7 bits that belong to the shift amount for immediate shifts on RV64.
  localparam logic [6:0] SH_FREE = (XLEN == 64) ? 7'b0000001 : 7'b0000000;

  logic [1:0]      state_q, state_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, q_q, q_d, rd_q, rd_d;
  logic [1:0]      op_q, op_d;
  logic            neg_q, neg_d, valid_q, valid_d;

  logic            is_r, is_i, is_m, alt, base_ok, sgn, sa, sb, ovf, ge;
  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] opb, sra_res, base_res, abs_a, abs_b, fast_res;
  logic [XLEN-1:0] r_nxt, q_nxt, div_sel, div_res, mul_res;
  logic [XLEN:0]   trial;

  function automatic logic [XLEN-1:0] mul_fn(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                             input logic [1:0] f);
    logic [2*XLEN-1:0] ea, eb, p;
    // MUL/MULH/MULHSU treat rs1 as signed; only MUL/MULH treat rs2 as signed.
    ea = {{XLEN{a[XLEN-1] & (f != 2'b11)}}, a};
    eb = {{XLEN{b[XLEN-1] & ~f[1]}}, b};
    p  = ea * eb;
    return (f == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  assign o_ready   = (state_q == S_IDLE);
  assign o_valid   = valid_q;
  assign o_rd_data = rd_q;

  always_comb begin
    is_r    = (i_opcode == 7'b0110011);
    is_i    = (i_opcode == 7'b0010011);
    is_m    = is_r & (i_funct7 == 7'b0000001);
    alt     = i_funct7[5];
    opb     = is_r ? i_rs2_data : i_imm;
    shamt   = opb[SW-1:0];
    sra_res = $signed(i_rs1_data) >>> shamt;
    base_ok = is_r ? ((i_funct7 == 7'b0000000) |
                      ((i_funct7 == 7'b0100000) & ((i_funct3 == 3'b000) | (i_funct3 == 3'b101))))
            : is_i & ((i_funct3 == 3'b001) ? ((i_funct7 & ~SH_FREE) == 7'b0) :
                      (i_funct3 == 3'b101) ? ((i_funct7 & ~(SH_FREE | 7'b0100000)) == 7'b0) : 1'b1);
    case (i_funct3)
      3'b000:  base_res = (is_r & alt) ? i_rs1_data - opb : i_rs1_data + opb;
      3'b001:  base_res = i_rs1_data << shamt;
      3'b010:  base_res = {{(XLEN-1){1'b0}}, $signed(i_rs1_data) < $signed(opb)};
      3'b011:  base_res = {{(XLEN-1){1'b0}}, i_rs1_data < opb};
      3'b100:  base_res = i_rs1_data ^ opb;
      3'b101:  base_res = alt ? sra_res : i_rs1_data >> shamt;
      3'b110:  base_res = i_rs1_data | opb;
      default: base_res = i_rs1_data & opb;
    endcase
    sgn   = ~i_funct3[0];
    sa    = sgn & i_rs1_data[XLEN-1];
    sb    = sgn & i_rs2_data[XLEN-1];
    abs_a = sa ? -i_rs1_data : i_rs1_data;
    abs_b = sb ? -i_rs2_data : i_rs2_data;
    ovf   = sgn & (i_rs1_data == {1'b1, {(XLEN-1){1'b0}}}) & (&i_rs2_data);
    // A single-cycle multiplier reads the issue operands; otherwise the captured ones.
    mul_res = mul_fn(MUL_CYCLES == 1 ? i_rs1_data : a_q, MUL_CYCLES == 1 ? i_rs2_data : b_q,
                     MUL_CYCLES == 1 ? i_funct3[1:0] : op_q);
    // Divide-by-zero and signed overflow resolve without iterating.
    fast_res = ~is_m ? (base_ok ? base_res : '0)
             : ~i_funct3[2] ? mul_res
             : (i_rs2_data == '0) ? (i_funct3[1] ? i_rs1_data : '1)
             : (i_funct3[1] ? '0 : i_rs1_data);
    // Restoring step: a_q is the partial remainder, q_q shifts dividend bits out and quotient bits in.
    trial   = {a_q, q_q[XLEN-1]} - {1'b0, b_q};
    ge      = ~trial[XLEN];
    r_nxt   = ge ? trial[XLEN-1:0] : {a_q[XLEN-2:0], q_q[XLEN-1]};
    q_nxt   = {q_q[XLEN-2:0], ge};
    div_sel = op_q[1] ? r_nxt : q_nxt;
    div_res = neg_q ? -div_sel : div_sel;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    q_d     = q_q;
    op_d    = op_q;
    neg_d   = neg_q;
    valid_d = 1'b0;
    rd_d    = rd_q;
    if (i_flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (state_q == S_IDLE) begin
      if (i_valid) begin
        op_d = i_funct3[1:0];
        if (is_m & ~i_funct3[2] & (MUL_CYCLES > 1)) begin
          state_d = S_MUL;
          cnt_d   = SW'(MUL_INIT);
          a_d     = i_rs1_data;
          b_d     = i_rs2_data;
        end else if (is_m & i_funct3[2] & (i_rs2_data != '0) & ~ovf) begin
          state_d = S_DIV;
          cnt_d   = SW'(XLEN - 1);
          a_d     = '0;
          q_d     = abs_a;
          b_d     = abs_b;
          neg_d   = i_funct3[1] ? sa : sa ^ sb;
        end else begin
          valid_d = 1'b1;
          rd_d    = fast_res;
        end
      end
    end else if (state_q == S_MUL) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == '0) begin
        state_d = S_IDLE;
        cnt_d   = '0;
        valid_d = 1'b1;
        rd_d    = mul_res;
      end
    end else begin
      a_d   = r_nxt;
      q_d   = q_nxt;
      cnt_d = cnt_q - 1'b1;
      // The last step and the sign fix share the final edge.
      if (cnt_q == '0) begin
        state_d = S_IDLE;
        cnt_d   = '0;
        valid_d = 1'b1;
        rd_d    = div_res;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      valid_q <= 1'b0;
      rd_q    <= '0;
    end else if (clk_en) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      q_q     <= q_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      valid_q <= valid_d;
      rd_q    <= rd_d;
    end
  end
endmodule

// File: tb/tb_alu_mext.sv
// tb_alu_mext: vector table, randomized model comparison and corner sequences for alu_mext.
module tb_alu_mext;
  localparam int XLEN = 32;
  localparam int MC   = 2;
  localparam logic [6:0] OPR = 7'h33, OPI = 7'h13;

  logic        clk = 1'b0, rst = 1'b0, clk_en = 1'b1, i_valid = 1'b0, i_flush = 1'b0;
  logic        o_ready, o_valid;
  logic [6:0]  i_opcode = '0, i_funct7 = '0;
  logic [2:0]  i_funct3 = '0;
  logic [31:0] i_rs1_data = '0, i_rs2_data = '0, i_imm = '0, o_rd_data;

  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  alu_mext #(.XLEN(XLEN), .MUL_CYCLES(MC)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .i_valid(i_valid), .o_ready(o_ready),
    .i_flush(i_flush), .i_opcode(i_opcode), .i_funct3(i_funct3), .i_funct7(i_funct7),
    .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_imm(i_imm),
    .o_valid(o_valid), .o_rd_data(o_rd_data)
  );

  typedef struct packed {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a, b, imm, exp;
    logic [7:0]  lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic void model(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                                output logic [31:0] r, output int lat);
    int sa, sb, sh;
    longint p;
    logic [63:0] pu;
    logic [31:0] y;
    bit ok;
    sa = a;
    sb = b;
    y = (opc == OPR) ? b : imm;
    sh = int'(y[4:0]);
    lat = 1;
    r = '0;
    if (opc == OPR && f7 == 7'h01) begin
      if (!f3[2]) begin
        lat = MC;
        case (f3[1:0])
          2'd0: begin p = longint'(sa) * longint'(sb); r = p[31:0]; end
          2'd1: begin p = longint'(sa) * longint'(sb); r = p[63:32]; end
          2'd2: begin p = longint'(sa) * longint'({32'b0, b}); r = p[63:32]; end
          default: begin pu = {32'b0, a} * {32'b0, b}; r = pu[63:32]; end
        endcase
      end else if (b == 0) r = f3[1] ? a : 32'hffffffff;
      else if (!f3[0] && a == 32'h80000000 && b == 32'hffffffff) r = f3[1] ? 32'h0 : a;
      else begin
        lat = XLEN + 1;
        case (f3[1:0])
          2'd0: r = sa / sb;
          2'd1: r = a / b;
          2'd2: r = sa % sb;
          default: r = a % b;
        endcase
      end
    end else begin
      ok = (opc == OPR) ? (f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5))) :
           (opc == OPI) ? ((f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 7'h20) : 1'b1) : 1'b0;
      if (ok)
        case (f3)
          3'd0: r = (opc == OPR && f7[5]) ? a - y : a + y;
          3'd1: r = a << sh;
          3'd2: r = (sa < int'(y)) ? 32'd1 : 32'd0;
          3'd3: r = (a < y) ? 32'd1 : 32'd0;
          3'd4: r = a ^ y;
          3'd5: r = f7[5] ? 32'(sa >>> sh) : a >> sh;
          3'd6: r = a | y;
          default: r = a & y;
        endcase
    end
  endfunction

  task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                       output logic [31:0] data, output int lat, output bit rdy_ok);
    @(negedge clk);
    rdy_ok = o_ready;
    i_opcode = opc; i_funct3 = f3; i_funct7 = f7;
    i_rs1_data = a; i_rs2_data = b; i_imm = imm;
    i_valid = 1'b1;
    @(posedge clk);
    #1 i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 100) begin
      if (o_ready) rdy_ok = 1'b0;
      @(posedge clk);
      #1 lat++;
    end
    data = o_rd_data;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hffffffff;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  vec_t vt[27];
  logic [31:0] data, exp, prev, imm;
  logic [11:0] t;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  int lat, elat, strobes;
  bit rdy;

  initial begin
    vt[0]  = '{OPR, 3'd0, 7'h00, 32'h7fffffff, 32'd1, 32'd0, 32'h80000000, 8'd1};
    vt[1]  = '{OPR, 3'd5, 7'h20, 32'h80000000, 32'd4, 32'd0, 32'hf8000000, 8'd1};
    vt[2]  = '{OPR, 3'd0, 7'h20, 32'd5, 32'd7, 32'd0, 32'hfffffffe, 8'd1};
    vt[3]  = '{OPR, 3'd2, 7'h00, 32'hffffffff, 32'd1, 32'd0, 32'd1, 8'd1};
    vt[4]  = '{OPR, 3'd3, 7'h00, 32'hffffffff, 32'd1, 32'd0, 32'd0, 8'd1};
    vt[5]  = '{OPI, 3'd1, 7'h00, 32'd1, 32'd0, 32'h1f, 32'h80000000, 8'd1};
    vt[6]  = '{OPI, 3'd5, 7'h20, 32'h80000000, 32'd0, 32'h404, 32'hf8000000, 8'd1};
    vt[7]  = '{OPI, 3'd4, 7'h00, 32'hf0f0f0f0, 32'd0, 32'hffffffff, 32'h0f0f0f0f, 8'd1};
    vt[8]  = '{OPI, 3'd3, 7'h00, 32'd5, 32'd0, 32'hffffffff, 32'd1, 8'd1};
    vt[9]  = '{OPR, 3'd1, 7'h01, 32'hffffffff, 32'hffffffff, 32'd0, 32'h0, 8'd2};
    vt[10] = '{OPR, 3'd3, 7'h01, 32'hffffffff, 32'hffffffff, 32'd0, 32'hfffffffe, 8'd2};
    vt[11] = '{OPR, 3'd0, 7'h01, 32'd7, 32'hfffffffd, 32'd0, 32'hffffffeb, 8'd2};
    vt[12] = '{OPR, 3'd2, 7'h01, 32'hffffffff, 32'd2, 32'd0, 32'hffffffff, 8'd2};
    vt[13] = '{OPR, 3'd4, 7'h01, 32'hfffffff9, 32'd2, 32'd0, 32'hfffffffd, 8'd33};
    vt[14] = '{OPR, 3'd6, 7'h01, 32'hfffffff9, 32'd2, 32'd0, 32'hffffffff, 8'd33};
    vt[15] = '{OPR, 3'd5, 7'h01, 32'd5, 32'd0, 32'd0, 32'hffffffff, 8'd1};
    vt[16] = '{OPR, 3'd4, 7'h01, 32'h80000000, 32'hffffffff, 32'd0, 32'h80000000, 8'd1};
    vt[17] = '{OPR, 3'd6, 7'h01, 32'h80000000, 32'hffffffff, 32'd0, 32'h0, 8'd1};
    vt[18] = '{OPR, 3'd7, 7'h01, 32'd5, 32'd0, 32'd0, 32'd5, 8'd1};
    vt[19] = '{OPR, 3'd0, 7'h02, 32'd5, 32'd5, 32'd0, 32'h0, 8'd1};
    vt[20] = '{OPR, 3'd5, 7'h01, 32'd100, 32'd7, 32'd0, 32'd14, 8'd33};
    vt[21] = '{7'h7f, 3'd0, 7'h00, 32'd5, 32'd5, 32'd5, 32'h0, 8'd1};
    vt[22] = '{OPR, 3'd7, 7'h01, 32'd100, 32'd7, 32'd0, 32'd2, 8'd33};
    vt[23] = '{OPR, 3'd1, 7'h20, 32'd1, 32'd1, 32'd0, 32'h0, 8'd1};
    vt[24] = '{OPR, 3'd6, 7'h01, 32'd7, 32'hfffffffe, 32'd0, 32'd1, 8'd33};
    vt[25] = '{OPR, 3'd4, 7'h01, 32'd7, 32'hfffffffe, 32'd0, 32'hfffffffd, 8'd33};
    vt[26] = '{OPI, 3'd0, 7'h00, 32'd3, 32'd0, 32'd4, 32'd7, 8'd1};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 32'(o_valid), 32'd0);
    chk("reset_data", o_rd_data, 32'd0);
    chk("reset_ready", 32'(o_ready), 32'd1);
    @(negedge clk) rst = 1'b1;

    for (int i = 0; i < 27; i++) begin
      issue(vt[i].opc, vt[i].f3, vt[i].f7, vt[i].a, vt[i].b, vt[i].imm, data, lat, rdy);
      chk($sformatf("vec%0d_data", i), data, vt[i].exp);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].lat));
      chk($sformatf("vec%0d_ready", i), 32'(rdy), 32'd1);
    end

    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0: begin opc = OPR; f7 = ((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00; end
        1: begin opc = OPI; f7 = (f3 == 5 && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00; end
        default: begin opc = OPR; f7 = 7'h01; end
      endcase
      t = 12'($urandom);
      imm = {{20{t[11]}}, t};
      prev = pick();
      data = pick();
      model(opc, f3, f7, prev, data, imm, exp, elat);
      issue(opc, f3, f7, prev, data, imm, data, lat, rdy);
      chk($sformatf("rand%0d_data", i), data, exp);
      chk($sformatf("rand%0d_latency", i), 32'(lat), 32'(elat));
      chk($sformatf("rand%0d_ready", i), 32'(rdy), 32'd1);
    end

    // Back-to-back base ops give strobes on consecutive cycles.
    @(negedge clk);
    i_opcode = OPR; i_funct3 = 3'd0; i_funct7 = 7'h00;
    i_rs1_data = 32'h7fffffff; i_rs2_data = 32'd1; i_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("b2b_valid0", 32'(o_valid), 32'd1);
    chk("b2b_data0", o_rd_data, 32'h80000000);
    i_funct3 = 3'd5; i_funct7 = 7'h20; i_rs1_data = 32'h80000000; i_rs2_data = 32'd4;
    @(posedge clk);
    #1 i_valid = 1'b0;
    chk("b2b_valid1", 32'(o_valid), 32'd1);
    chk("b2b_data1", o_rd_data, 32'hf8000000);
    @(posedge clk);
    #1 chk("b2b_valid_drop", 32'(o_valid), 32'd0);

    // Flush ten cycles into a divide.
    issue(OPI, 3'd0, 7'h00, 32'h1234, 32'd0, 32'd0, data, lat, rdy);
    chk("preflush_data", data, 32'h1234);
    @(negedge clk);
    i_opcode = OPR; i_funct3 = 3'd4; i_funct7 = 7'h01;
    i_rs1_data = 32'hfffffff9; i_rs2_data = 32'd2; i_valid = 1'b1;
    @(posedge clk);
    #1 i_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk) i_flush = 1'b1;
    @(posedge clk);
    #1;
    chk("flush_valid", 32'(o_valid), 32'd0);
    chk("flush_ready", 32'(o_ready), 32'd1);
    chk("flush_hold_data", o_rd_data, 32'h1234);
    i_flush = 1'b0;
    i_opcode = OPI; i_funct3 = 3'd0; i_funct7 = 7'h00;
    i_rs1_data = 32'd3; i_imm = 32'd4; i_valid = 1'b1;
    @(posedge clk);
    #1 i_valid = 1'b0;
    chk("post_flush_valid", 32'(o_valid), 32'd1);
    chk("post_flush_data", o_rd_data, 32'd7);
    strobes = 0;
    repeat (40) begin @(posedge clk); #1 if (o_valid) strobes++; end
    chk("flush_no_late_valid", 32'(strobes), 32'd0);

    // Five disabled edges mid-divide stretch latency by five.
    @(negedge clk);
    i_opcode = OPR; i_funct3 = 3'd5; i_funct7 = 7'h01;
    i_rs1_data = 32'd100; i_rs2_data = 32'd7; i_valid = 1'b1;
    @(posedge clk);
    #1 i_valid = 1'b0;
    lat = 1;
    rdy = 1'b1;
    while (!o_valid && lat < 100) begin
      if (lat == 10) clk_en = 1'b0;
      if (lat == 15) clk_en = 1'b1;
      if (o_ready) rdy = 1'b0;
      @(posedge clk);
      #1 lat++;
    end
    clk_en = 1'b1;
    chk("stall_latency", 32'(lat), 32'd38);
    chk("stall_data", o_rd_data, 32'd14);
    chk("stall_ready_low", 32'(rdy), 32'd1);

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    i_opcode = OPR; i_funct3 = 3'd4; i_funct7 = 7'h01;
    i_rs1_data = 32'hfffffff9; i_rs2_data = 32'd2; i_valid = 1'b1;
    @(posedge clk);
    #1 i_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("midrst_valid", 32'(o_valid), 32'd0);
    chk("midrst_data", o_rd_data, 32'd0);
    chk("midrst_ready", 32'(o_ready), 32'd1);
    @(negedge clk) rst = 1'b1;
    strobes = 0;
    repeat (40) begin @(posedge clk); #1 if (o_valid) strobes++; end
    chk("midrst_no_valid", 32'(strobes), 32'd0);
    issue(OPI, 3'd0, 7'h00, 32'd3, 32'd0, 32'd4, data, lat, rdy);
    chk("post_rst_data", data, 32'd7);
    chk("post_rst_latency", 32'(lat), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
